// File: rtl/muxdisp_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan engine.
// Segment patterns are active-high and indexed a=0 .. g=6, dp=7 on [0:7] vectors,
// so bit index equals segment index everywhere in this block.
package muxdisp_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } muxdisp_state_t;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Leftmost literal bit is segment a, rightmost is g.
    localparam logic [0:6] HEX_PATTERNS [0:15] = '{
        7'b1111110,  // 0
        7'b0110000,  // 1
        7'b1101101,  // 2
        7'b1111001,  // 3
        7'b0110011,  // 4
        7'b1011011,  // 5
        7'b1011111,  // 6
        7'b1110000,  // 7
        7'b1111111,  // 8
        7'b1111011,  // 9
        7'b1110111,  // A
        7'b0011111,  // b
        7'b1001110,  // C
        7'b0111101,  // d
        7'b1001111,  // E
        7'b1000111   // F
    };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble + decimal point to active-high segment pattern.
module seg7_hex_decoder
    import muxdisp_pkg::*;
(
    input  logic [0:3] nibble_i,
    input  logic       dp_i,
    output logic [0:7] pat_o
);

    // Table lookup for a..g, dp passed straight through.
    always_comb begin
        pat_o                = '0;
        pat_o[SEG_A:SEG_G]   = HEX_PATTERNS[nibble_i];
        pat_o[SEG_DP]        = dp_i;
    end

endmodule

// File: rtl/muxdisp_scan_core.sv
// Four-digit multiplexed seven-segment scan engine.
// Each digit slot starts with a blanking gap (all anodes off) followed by the
// display phase; the digit pattern is captured at the start of the display
// phase so register writes never change a digit mid-slot.
// Build option: define MUXDISP_HEX_DECODE_EN to decode wr_data[4:7] as a hex
// nibble (wr_data[0] = dp) at write time; otherwise wr_data is stored raw.
module muxdisp_scan_core
    import muxdisp_pkg::*;
#(
    parameter int C_DIGIT_PERIOD_CYCLES = 66667,
    parameter int C_BLANK_CYCLES        = 64
) (
    input  logic       SPLB_Clk,
    input  logic       SPLB_Rst,
    input  logic       wr_en,
    input  logic [0:1] wr_addr,
    input  logic [0:7] wr_data,
    input  logic       disp_en,
    output logic [0:7] segments,
    output logic [0:3] anodes,
    output logic       frame_done
);

    localparam int CNT_W = $clog2(C_DIGIT_PERIOD_CYCLES);
    localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'(C_BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(C_DIGIT_PERIOD_CYCLES - 1);

    logic [0:7]       wr_pat;
    logic [0:7]       digit_reg_q [0:3];

    muxdisp_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [0:7]       show_pat_q, show_pat_d;
    logic [0:3]       anodes_q, anodes_d;
    logic [0:7]       segments_q, segments_d;
    logic             frame_done_q, frame_done_d;

`ifdef MUXDISP_HEX_DECODE_EN
    logic [0:2] unused_wr_bits;
    assign unused_wr_bits = wr_data[1:3];

    seg7_hex_decoder u_hex_decoder (
        .nibble_i (wr_data[4:7]),
        .dp_i     (wr_data[0]),
        .pat_o    (wr_pat)
    );
`else
    assign wr_pat = wr_data;
`endif

    // Digit storage: one normalized pattern per digit, last write wins.
    always_ff @(posedge SPLB_Clk or posedge SPLB_Rst) begin
        if (SPLB_Rst) begin
            for (int i = 0; i < 4; i++) digit_reg_q[i] <= '0;
        end else if (wr_en) begin
            digit_reg_q[wr_addr] <= wr_pat;
        end
    end

    // Next-state logic: slot counter, digit index, pattern capture, outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        idx_d        = idx_q;
        show_pat_d   = show_pat_q;
        frame_done_d = 1'b0;
        anodes_d     = 4'b1111;
        segments_d   = 8'hFF;

        case (state_q)
            S_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d    = S_SHOW;
                    show_pat_d = digit_reg_q[idx_q];
                end
            end
            S_SHOW: begin
                if (cnt_q == PERIOD_LAST) begin
                    state_d      = S_BLANK;
                    cnt_d        = '0;
                    idx_d        = idx_q + 2'd1;
                    frame_done_d = (idx_q == 2'd3);
                end
            end
            default: begin
                state_d = S_BLANK;
                cnt_d   = '0;
            end
        endcase

        // Outputs follow the next state so they change on the transition edge.
        if (state_d == S_SHOW && disp_en) begin
            anodes_d[idx_d] = 1'b0;
            segments_d      = ~show_pat_d;
        end
    end

    // State and output registers; reset forces the pins dark immediately.
    always_ff @(posedge SPLB_Clk or posedge SPLB_Rst) begin
        if (SPLB_Rst) begin
            state_q      <= S_BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            show_pat_q   <= '0;
            anodes_q     <= 4'b1111;
            segments_q   <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            show_pat_q   <= show_pat_d;
            anodes_q     <= anodes_d;
            segments_q   <= segments_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign anodes     = anodes_q;
    assign segments   = segments_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/muxdisp_scan_core.md
# muxdisp_scan_core

Scan engine for the four-digit multiplexed seven-segment display peripheral. Sits directly downstream of the PLB slave register logic. Holds one segment byte per digit, written through a simple register-write strobe. Time-multiplexes the digits onto the board's active-low `segments`/`anodes` pins, with a blanking gap between digits to suppress ghosting.

## Interface
Parameters:
- `C_DIGIT_PERIOD_CYCLES`, default 66667: total clocks per digit slot, blank included (1 ms at 15000 ps clock); must be > `C_BLANK_CYCLES`.
- `C_BLANK_CYCLES`, default 64: clocks with all anodes off at the start of each slot; ≥ 1.

Ports:
- `SPLB_Clk`, in, 1: the only clock.
- `SPLB_Rst`, in, 1: reset, asynchronous, active-high.
- `wr_en`, in, 1: one-cycle write strobe from the register logic.
- `wr_addr`, in, [0:1]: digit index 0–3.
- `wr_data`, in, [0:7]: digit data; encoding is set by the macro in Configuration.
- `disp_en`, in, 1: when 0, all digits are forced dark.
- `segments`, out, [0:7]: active-low; [0]=a … [6]=g, [7]=dp.
- `anodes`, out, [0:3]: active-low; [0] is the leftmost digit (digit 0).
- `frame_done`, out, 1: one-cycle pulse at the end of digit 3's slot.

## Operation
- Storage: `digit_reg[0..3]`, 8 bits each, hold a normalized active-high pattern (bit0=a … bit7=dp). Written on `wr_en` at `wr_addr`.
- FSM states:
  - `S_BLANK`: counter 0..`C_BLANK_CYCLES`-1; all outputs dark.
  - `S_SHOW`: counter continues to `C_DIGIT_PERIOD_CYCLES`-1.
- Transitions:
  - BLANK→SHOW on the last blank count. On this transition, `digit_reg[idx]` is latched into `show_pat`.
  - SHOW→BLANK on the last count. Counter clears and `idx` increments, wrapping 3→0.
  - On the 3→0 wrap, `frame_done` pulses.
- Outputs are registered and derived from the next state:
  - In SHOW with `disp_en`=1: `anodes` has only bit `idx` low; `segments` = ~`show_pat`.
  - Otherwise: `anodes`=4'b1111, `segments`=8'hFF.
- `disp_en`=0 gates the outputs only. Counter, `idx` and `frame_done` keep running.
- Reset values: state BLANK, counter 0, `idx` 0, all `digit_reg` 0, `show_pat` 0, `anodes`=4'b1111, `segments`=8'hFF, `frame_done`=0.

## Timing
- After reset release, `anodes[0]` falls on rising edge `C_BLANK_CYCLES`.
- Each anode is low for `C_DIGIT_PERIOD_CYCLES`-`C_BLANK_CYCLES` clocks.
- Frame period is 4×`C_DIGIT_PERIOD_CYCLES`. `frame_done` is high for the one clock following SHOW(3)'s last cycle.
- Write latency: a write is visible from the next SHOW entry of that digit, never mid-slot.
- Write in the same cycle as the BLANK→SHOW latch of the same digit: the old value is shown; the new value appears next frame.
- Back-to-back writes to the same address: the last one wins.
- Asynchronous reset mid-SHOW: outputs go dark immediately, without waiting for a clock edge.

## Configuration
- `MUXDISP_HEX_DECODE_EN` defined:
  - `wr_data[4:7]` is a hex nibble, decoded to segments a–g (0–9, A, b, C, d, E, F).
  - `wr_data[0]` drives dp.
  - `wr_data[1:3]` are ignored.
  - Decoding happens at write time.
- Not defined: `wr_data` is stored raw as the active-high pattern (bit0=a … bit7=dp), and no decoder is instantiated.

## Structure
- `muxdisp_pkg` contains:
  - state enum `muxdisp_state_t`;
  - segment bit-index constants `SEG_A`..`SEG_DP`;
  - the 16-entry hex pattern constant table.
- Sub-module `seg7_hex_decoder`: combinational nibble+dp → pattern. Instantiated only under `MUXDISP_HEX_DECODE_EN`.

## Test plan
All scenarios use `C_DIGIT_PERIOD_CYCLES`=16, `C_BLANK_CYCLES`=4 and `disp_en`=1 unless noted.
1. Reset:
   - Stimulus: assert `SPLB_Rst`, then release.
   - Required response: `segments`=8'hFF, `anodes`=4'hF and `frame_done`=0 while in reset. `anodes`=4'b0111 from edge 4 to edge 15. `segments`=8'hFF, since the digits are 0 in raw mode.
2. Hex decode (macro on):
   - Stimulus: write addr 0 = 8'h05, then addr 1 = 8'h85.
   - Required response: `segments`=8'h49 while `anodes`=0111. `segments`=8'h48 while `anodes`=1011.
3. Scan order:
   - Stimulus: let the scan run freely.
   - Required response: anodes cycle 0111, 1011, 1101, 1110. Each is low for 12 clocks, followed by 4 clocks of 1111. `frame_done` pulses every 64 clocks.
4. Mid-slot write (raw mode):
   - Stimulus: write addr 2 = 8'h01 while digit 2 is showing.
   - Required response: `segments` is unchanged for the rest of that slot. On the next digit-2 slot, `segments`=8'hFE.
5. Display disable:
   - Stimulus: `disp_en`=0 for 100 clocks.
   - Required response: `anodes`=4'hF and `segments`=8'hFF throughout; `frame_done` still pulses at the 64-clock spacing.
6. Reset mid-operation:
   - Stimulus: assert `SPLB_Rst` between clock edges during SHOW(1).
   - Required response: outputs go dark without waiting for a clock edge, and `digit_reg` clears. After release, the scan restarts from digit 0.
